// File: rtl/sliced_alu_exec.sv
// Multi-cycle execute unit: ADD/SUB/AND/OR/XOR computed SLICE_WIDTH bits per cycle, LSB slice first.
// Optional signed-overflow output enabled by defining SLICED_ALU_OVF_EN.
module sliced_alu_exec #(
    parameter int DATA_WIDTH  = 64,
    parameter int SLICE_WIDTH = 16,
    parameter int OP_WIDTH    = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [OP_WIDTH-1:0]   i_ALU_Operation,
    input  logic [DATA_WIDTH-1:0] i_src_a,
    input  logic [DATA_WIDTH-1:0] i_src_b,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_result,
    output logic                  o_zero,
    output logic                  o_carry,
    output logic                  o_illegal
`ifdef SLICED_ALU_OVF_EN
    ,
    output logic                  o_overflow
`endif
);

    localparam int N  = DATA_WIDTH / SLICE_WIDTH;
    localparam int CW = (N + 1 > 2) ? $clog2(N + 1) : 1;

    localparam logic [OP_WIDTH-1:0] OP_ADD = OP_WIDTH'(1);
    localparam logic [OP_WIDTH-1:0] OP_SUB = OP_WIDTH'(2);
    localparam logic [OP_WIDTH-1:0] OP_AND = OP_WIDTH'(3);
    localparam logic [OP_WIDTH-1:0] OP_OR  = OP_WIDTH'(4);
    localparam logic [OP_WIDTH-1:0] OP_XOR = OP_WIDTH'(5);

    generate
        if (DATA_WIDTH % SLICE_WIDTH != 0) begin : g_width_check
            $error("sliced_alu_exec: DATA_WIDTH must be a multiple of SLICE_WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

    state_t                state_reg, state_next;
    logic [CW-1:0]         cnt_reg, cnt_next;
    logic [DATA_WIDTH-1:0] a_reg, a_next;
    logic [DATA_WIDTH-1:0] b_reg, b_next;
    logic [OP_WIDTH-1:0]   op_reg, op_next;
    logic [DATA_WIDTH-1:0] res_reg, res_next;
    logic                  cin_reg, cin_next;
    logic                  zero_reg, zero_next;
    logic                  carry_reg, carry_next;
    logic                  illegal_reg, illegal_next;
`ifdef SLICED_ALU_OVF_EN
    logic                  ovf_reg, ovf_next;
`endif

    logic [SLICE_WIDTH-1:0] a_slices [N];
    logic [SLICE_WIDTH-1:0] b_slices [N];

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_slice
            assign a_slices[gi] = a_reg[gi*SLICE_WIDTH +: SLICE_WIDTH];
            assign b_slices[gi] = b_reg[gi*SLICE_WIDTH +: SLICE_WIDTH];
        end
    endgenerate

    logic [SLICE_WIDTH-1:0] a_sl, b_sl, b_eff, slice_res;
    logic [SLICE_WIDTH:0]   sum_ext;
    logic                   is_sub, is_arith, op_legal;

    always_comb begin
        is_sub   = (op_reg == OP_SUB);
        is_arith = (op_reg == OP_ADD) || is_sub;
        op_legal = is_arith || (op_reg == OP_AND) || (op_reg == OP_OR) || (op_reg == OP_XOR);

        a_sl = '0;
        b_sl = '0;
        for (int k = 0; k < N; k++) begin
            if (cnt_reg == CW'(k)) begin
                a_sl = a_slices[k];
                b_sl = b_slices[k];
            end
        end

        // SUB is A + ~B + 1; the +1 enters as the initial carry-in set at accept.
        b_eff   = is_sub ? ~b_sl : b_sl;
        sum_ext = {1'b0, a_sl} + {1'b0, b_eff} + (SLICE_WIDTH + 1)'(cin_reg);

        case (op_reg)
            OP_ADD, OP_SUB: slice_res = sum_ext[SLICE_WIDTH-1:0];
            OP_AND:         slice_res = a_sl & b_sl;
            OP_OR:          slice_res = a_sl | b_sl;
            OP_XOR:         slice_res = a_sl ^ b_sl;
            default:        slice_res = '0;
        endcase
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        a_next       = a_reg;
        b_next       = b_reg;
        op_next      = op_reg;
        res_next     = res_reg;
        cin_next     = cin_reg;
        zero_next    = zero_reg;
        carry_next   = carry_reg;
        illegal_next = illegal_reg;
`ifdef SLICED_ALU_OVF_EN
        ovf_next     = ovf_reg;
`endif

        case (state_reg)
            S_IDLE: begin
                if (i_valid) begin
                    a_next     = i_src_a;
                    b_next     = i_src_b;
                    op_next    = i_ALU_Operation;
                    cnt_next   = '0;
                    cin_next   = (i_ALU_Operation == OP_SUB);
                    state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                // Counter value N is a finalize cycle that registers the status flags.
                if (cnt_reg == CW'(N)) begin
                    zero_next    = (res_reg == '0);
                    carry_next   = is_arith & cin_reg;
                    illegal_next = !op_legal;
`ifdef SLICED_ALU_OVF_EN
                    if (op_reg == OP_ADD)
                        ovf_next = (a_reg[DATA_WIDTH-1] == b_reg[DATA_WIDTH-1]) &&
                                   (res_reg[DATA_WIDTH-1] != a_reg[DATA_WIDTH-1]);
                    else if (is_sub)
                        ovf_next = (a_reg[DATA_WIDTH-1] != b_reg[DATA_WIDTH-1]) &&
                                   (res_reg[DATA_WIDTH-1] != a_reg[DATA_WIDTH-1]);
                    else
                        ovf_next = 1'b0;
`endif
                    state_next   = S_DONE;
                end else begin
                    for (int k = 0; k < N; k++) begin
                        if (cnt_reg == CW'(k))
                            res_next[k*SLICE_WIDTH +: SLICE_WIDTH] = slice_res;
                    end
                    cin_next = sum_ext[SLICE_WIDTH];
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            S_DONE: begin
                if (i_ready)
                    state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg   <= S_IDLE;
            cnt_reg     <= '0;
            a_reg       <= '0;
            b_reg       <= '0;
            op_reg      <= '0;
            res_reg     <= '0;
            cin_reg     <= 1'b0;
            zero_reg    <= 1'b1;
            carry_reg   <= 1'b0;
            illegal_reg <= 1'b0;
`ifdef SLICED_ALU_OVF_EN
            ovf_reg     <= 1'b0;
`endif
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            a_reg       <= a_next;
            b_reg       <= b_next;
            op_reg      <= op_next;
            res_reg     <= res_next;
            cin_reg     <= cin_next;
            zero_reg    <= zero_next;
            carry_reg   <= carry_next;
            illegal_reg <= illegal_next;
`ifdef SLICED_ALU_OVF_EN
            ovf_reg     <= ovf_next;
`endif
        end
    end

    assign o_ready   = (state_reg == S_IDLE);
    assign o_valid   = (state_reg == S_DONE);
    assign o_result  = res_reg;
    assign o_zero    = zero_reg;
    assign o_carry   = carry_reg;
    assign o_illegal = illegal_reg;
`ifdef SLICED_ALU_OVF_EN
    assign o_overflow = ovf_reg;
`endif

endmodule
